yuv422_to_yuv444: RTL and testbench
===================================

# yuv422_to_yuv444

Chroma upsampler that takes the interleaved 4:2:2 stream produced by the RGB-to-YUV422 front end (Y plus alternating Cb/Cr on one 8-bit lane) and restores a full 4:4:4 Y/Cb/Cr pixel stream with matched sync timing. It sits directly downstream of the 4:2:2 packer, ahead of the YCbCr-to-RGB converter or any per-pixel processing stage that needs co-sited chroma. Odd-pixel chroma is either replicated or linearly interpolated, selected by parameter.

## Interface
- INTERP, default 0: 0 = replicate pair chroma to both pixels; 1 = odd pixel gets average of current and next pair.
- LATENCY, derived (localparam): 2 when INTERP=0, 4 when INTERP=1.

- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- i_hs  in  1  horizontal sync, aligned with i_de/i_y/i_c.
- i_vs  in  1  vertical sync.
- i_de  in  1  active-video enable.
- i_y  in  8  luma.
- i_c  in  8  chroma lane: Cb on even pixel of each pair, Cr on odd.
- o_hs  out  1  i_hs delayed by LATENCY.
- o_vs  out  1  i_vs delayed by LATENCY.
- o_de  out  1  i_de delayed by LATENCY.
- o_y  out  8  luma delayed by LATENCY.
- o_cb  out  8  reconstructed Cb.
- o_cr  out  8  reconstructed Cr.

## Operation
- Phase bit: cleared on any cycle with i_de=0; toggles on every i_de=1 cycle. Phase 0 = even pixel (i_c is Cb_k), phase 1 = odd pixel (i_c is Cr_k). First active pixel of every line is always Cb regardless of previous line length.
- Pair k = (Y_2k, Cb_k), (Y_2k+1, Cr_k). Cb_k latched on phase 0, Cr_k on phase 1; pair marked complete on phase-1 cycle.
- INTERP=0: both pixels of pair k output with Cb_k, Cr_k.
- INTERP=1: even pixel 2k outputs Cb_k, Cr_k; odd pixel 2k+1 outputs (Cb_k+Cb_k+1+1)>>1 and (Cr_k+Cr_k+1+1)>>1, sums in 9 bits, no saturation needed.
- Line end, INTERP=1: last complete pair has no successor; its odd pixel uses Cb_k, Cr_k unchanged (replicate).
- Odd-length line: final pixel carries Cb only; its Cr is the previous pair's Cr_k of the same line, or 8'h80 if the line is a single pixel. In INTERP=1 the preceding odd pixel interpolates Cb with this lone Cb and uses Cr_k unaveraged.
- Blanking: whenever o_de=0, o_y=8'h00, o_cb=o_cr=8'h80.
- Sync pass-through: hs/vs/de go through a pure LATENCY-deep shift register; no edge regeneration.

## Timing
- Reset: o_hs=o_vs=o_de=0, o_y=0, o_cb=o_cr=8'h80; phase=0; all delay-line and chroma registers cleared (chroma to 8'h80). Reset mid-line: output returns to blanking immediately; next i_de after release starts a fresh line at phase 0.
- Input sample at cycle t appears at outputs on cycle t+LATENCY, all outputs registered, constant latency for every pixel incl. line edges.
- No backpressure; one pixel accepted and one produced per clock, continuous.
- i_de gap of a single cycle mid-line ends the line (phase reset, line-end replicate rule applies).
- i_vs/i_hs values are never inspected for control; only i_de drives phase.

## Structure
- Shared package constants: CHROMA_NEUTRAL = 8'h80, BLANK_Y = 8'h00, pixel width 8; reuse for the sibling 4:4:4-to-4:2:2 packer.
- One natural sub-module: sync_delay (parameterised depth/width shift register for hs/vs/de/y), instantiated with DEPTH=LATENCY.
- Core holds phase logic, pair capture registers, averaging and line-end detection.

## Test plan
- INTERP=0, 4-pixel line Y=10,20,30,40, C=50,60,70,80 -> after 2 cycles: (10,50,60),(20,50,60),(30,70,80),(40,70,80); o_de high exactly 4 cycles.
- INTERP=1, same line -> after 4 cycles: (10,50,60),(20,60,70),(30,70,80),(40,70,80); pixel 1 Cb=(50+70+1)>>1=60.
- Odd-length line of 3 pixels, C=100,200,101, INTERP=0 -> third pixel Cb=101, Cr=200; single-pixel line C=33 -> Cb=33, Cr=128.
- Rounding: INTERP=1, Cb_0=1, Cb_1=2 -> odd pixel Cb=2; Cb 255+255 -> 255 (no overflow).
- Back-to-back lines separated by one i_de=0 cycle, first line 5 pixels -> second line's first pixel treated as Cb; hs/vs delayed exactly LATENCY, blanking outputs 0/128/128.
- Assert rst during pixel 2 of a line -> outputs go to reset values asynchronously; after release, next line decodes correctly from phase 0.

Source files
------------

// File: rtl/yuv422_to_yuv444_pkg.sv
// Shared constants and helpers for the 4:2:2 <-> 4:4:4 chroma resampling blocks.
package yuv422_to_yuv444_pkg;

  localparam int PIX_W = 8;
  localparam logic [PIX_W-1:0] CHROMA_NEUTRAL = 8'h80;
  localparam logic [PIX_W-1:0] BLANK_Y        = 8'h00;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    pix_t y;
  } sync_t;

  // Rounded mean of two samples; the 9-bit sum cannot overflow.
  function automatic pix_t chroma_avg(pix_t a, pix_t b);
    logic [PIX_W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{PIX_W{1'b0}}, 1'b1};
    return s[PIX_W:1];
  endfunction

endpackage

// File: rtl/yuv422_to_yuv444_sync_delay.sv
// Fixed-depth shift register carrying sync and luma alongside the chroma path.
module sync_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/yuv422_to_yuv444.sv
// 4:2:2 interleaved chroma to 4:4:4 upsampler; replicate or interpolate odd-pixel chroma.
module yuv422_to_yuv444
  import yuv422_to_yuv444_pkg::*;
#(
  parameter int INTERP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_de,
  input  logic [PIX_W-1:0] i_y,
  input  logic [PIX_W-1:0] i_c,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de,
  output logic [PIX_W-1:0] o_y,
  output logic [PIX_W-1:0] o_cb,
  output logic [PIX_W-1:0] o_cr
);

  localparam int LATENCY = (INTERP != 0) ? 4 : 2;
  // Tap ages in the chroma window: CTR is the pixel being resolved this cycle.
  localparam int CTR  = LATENCY - 1;
  localparam int PRV  = CTR + 1;
  localparam int NXT  = CTR - 1;
  localparam int NXT2 = (CTR >= 2) ? CTR - 2 : 0;

  sync_t sync_in, sync_out;

  always_comb begin
    sync_in    = '0;
    sync_in.hs = i_hs;
    sync_in.vs = i_vs;
    sync_in.de = i_de;
    sync_in.y  = i_de ? i_y : BLANK_Y;
  end

  sync_delay #(
    .DEPTH (LATENCY),
    .WIDTH ($bits(sync_t))
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sync_in),
    .q_o (sync_out)
  );

  assign o_hs = sync_out.hs;
  assign o_vs = sync_out.vs;
  assign o_de = sync_out.de;
  assign o_y  = sync_out.y;

  logic                            phase_q;
  logic [CTR:1]                    ph_q;
  logic [LATENCY:1]                de_q;
  logic [LATENCY:1][PIX_W-1:0]     c_q;
  logic [PIX_W-1:0]                cb_q, cb_d, cr_q, cr_d;

  // Window index 0 is the live input, index j is the sample j cycles old.
  logic [CTR:0]                    w_ph;
  logic [LATENCY:0]                w_de;
  logic [LATENCY:0][PIX_W-1:0]     w_c;

  assign w_ph = {ph_q, phase_q};
  assign w_de = {de_q, i_de};
  assign w_c  = {c_q, i_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      ph_q    <= '0;
      de_q    <= '0;
      c_q     <= {LATENCY{CHROMA_NEUTRAL}};
      cb_q    <= CHROMA_NEUTRAL;
      cr_q    <= CHROMA_NEUTRAL;
    end else begin
      phase_q <= i_de & ~phase_q;
      ph_q    <= w_ph[CTR-1:0];
      de_q    <= w_de[LATENCY-1:0];
      c_q     <= w_c[LATENCY-1:0];
      cb_q    <= cb_d;
      cr_q    <= cr_d;
    end
  end

  always_comb begin
    cb_d = CHROMA_NEUTRAL;
    cr_d = CHROMA_NEUTRAL;
    if (w_de[CTR]) begin
      if (!w_ph[CTR]) begin
        // Even pixel: own Cb; Cr from its pair, else from the previous pair of a lone tail.
        cb_d = w_c[CTR];
        if (w_de[NXT])      cr_d = w_c[NXT];
        else if (w_de[PRV]) cr_d = w_c[PRV];
      end else begin
        cb_d = w_c[PRV];
        cr_d = w_c[CTR];
        if (INTERP != 0 && w_de[NXT]) begin
          cb_d = chroma_avg(w_c[PRV], w_c[NXT]);
          if (w_de[NXT2]) cr_d = chroma_avg(w_c[CTR], w_c[NXT2]);
        end
      end
    end
  end

  assign o_cb = cb_q;
  assign o_cr = cr_q;

endmodule

// File: tb/tb_yuv422_to_yuv444.sv
// Bench: replicate and interpolate variants side by side against a line-level reference model.
module tb_yuv422_to_yuv444;

  localparam int N = 1500;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_hs, i_vs, i_de;
  logic [7:0] i_y, i_c;
  logic       o_hs0, o_vs0, o_de0, o_hs1, o_vs1, o_de1;
  logic [7:0] o_y0, o_cb0, o_cr0, o_y1, o_cb1, o_cr1;

  always #5 clk = ~clk;

  yuv422_to_yuv444 #(.INTERP(0)) u_rep (
    .clk(clk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_y(i_y), .i_c(i_c),
    .o_hs(o_hs0), .o_vs(o_vs0), .o_de(o_de0), .o_y(o_y0), .o_cb(o_cb0), .o_cr(o_cr0)
  );

  yuv422_to_yuv444 #(.INTERP(1)) u_int (
    .clk(clk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_y(i_y), .i_c(i_c),
    .o_hs(o_hs1), .o_vs(o_vs1), .o_de(o_de1), .o_y(o_y1), .o_cb(o_cb1), .o_cr(o_cr1)
  );

  bit         hde[N], hhs[N], hvs[N], hrst[N];
  logic [7:0] hy[N], hc[N];
  int         w, checks, errors, valid_from;
  int         a0, b0, c0, d0, e0;

  typedef struct {
    bit hs, vs, de;
    int y, cb, cr;
  } exp_t;

  // Reference: locate the line containing pixel s, form its pair and apply the chroma rules.
  function automatic exp_t model(int interp, int s, int vf);
    exp_t e;
    int start, pos, b, cbk, crk;
    e.hs = 0; e.vs = 0; e.de = 0; e.y = 0; e.cb = 128; e.cr = 128;
    if (s < 0 || s < vf || s >= N) return e;
    e.hs = hhs[s];
    e.vs = hvs[s];
    if (!hde[s]) return e;
    e.de = 1;
    e.y  = int'(hy[s]);
    start = s;
    while (start - 1 >= vf && hde[start-1]) start--;
    pos = s - start;
    b   = start + (pos / 2) * 2;
    cbk = int'(hc[b]);
    if (b + 1 < N && hde[b+1]) crk = int'(hc[b+1]);
    else if (b > start)        crk = int'(hc[b-1]);
    else                       crk = 128;
    e.cb = cbk;
    e.cr = crk;
    if (interp != 0 && (pos % 2) == 1 && b + 2 < N && hde[b+2]) begin
      e.cb = (cbk + int'(hc[b+2]) + 1) / 2;
      if (b + 3 < N && hde[b+3]) e.cr = (crk + int'(hc[b+3]) + 1) / 2;
    end
    return e;
  endfunction

  task automatic put(bit de, int y, int c, bit r = 0);
    hde[w]  = de && !r;
    hy[w]   = 8'(y);
    hc[w]   = 8'(c);
    hrst[w] = r;
    hhs[w]  = r ? 1'b0 : 1'($urandom_range(0, 1));
    hvs[w]  = r ? 1'b0 : 1'($urandom_range(0, 1));
    w++;
  endtask

  task automatic blank(int k);
    for (int i = 0; i < k; i++) put(0, 0, 0);
  endtask

  task automatic chk(string nm, logic hs, logic vs, logic de, logic [7:0] y,
                     logic [7:0] cb, logic [7:0] cr, exp_t e);
    checks++;
    if ({hs, vs, de} !== {e.hs, e.vs, e.de} || y !== 8'(e.y) || cb !== 8'(e.cb) || cr !== 8'(e.cr)) begin
      errors++;
      $display("FAIL %s @%0t: got hs=%0b vs=%0b de=%0b y=%0d cb=%0d cr=%0d, want hs=%0b vs=%0b de=%0b y=%0d cb=%0d cr=%0d",
               nm, $time, hs, vs, de, y, cb, cr, e.hs, e.vs, e.de, e.y, e.cb, e.cr);
    end
  endtask

  task automatic pin(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL pin_%s: model gives %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic drive(int n);
    if (n < N) begin
      i_de = hde[n]; i_hs = hhs[n]; i_vs = hvs[n]; i_y = hy[n]; i_c = hc[n];
    end else begin
      i_de = 0; i_hs = 0; i_vs = 0; i_y = 0; i_c = 0;
    end
  endtask

  initial begin
    exp_t rz;
    int   len, gap;
    checks = 0; errors = 0; w = 0; valid_from = 0;

    blank(3);
    a0 = w; put(1, 10, 50); put(1, 20, 60); put(1, 30, 70); put(1, 40, 80);
    blank(3);
    b0 = w; put(1, 1, 100); put(1, 2, 200); put(1, 3, 101);
    blank(2);
    c0 = w; put(1, 7, 33);
    blank(2);
    d0 = w; put(1, 5, 1); put(1, 6, 9); put(1, 7, 2); put(1, 8, 9);
    put(1, 9, 255); put(1, 10, 8); put(1, 11, 255); put(1, 12, 8);
    blank(2);
    e0 = w; for (int i = 0; i < 5; i++) put(1, 90 + i, 11 + i);
    blank(1);
    for (int i = 0; i < 4; i++) put(1, 95 + i, 21 + i);
    blank(3);
    put(1, 30, 3); put(1, 31, 4);
    put(0, 0, 0, 1); put(0, 0, 0, 1);
    blank(1);
    for (int i = 0; i < 4; i++) put(1, 60 + i, 40 + i);
    blank(3);
    while (w < N - 30) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 60) == 0) put(0, 0, 0, 1);
        else put(1, $urandom_range(0, 255), $urandom_range(0, 255));
      end
      gap = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 4) : 1;
      blank(gap);
    end
    while (w < N) put(0, 0, 0);

    // Hand-derived values that anchor the reference model.
    pin("rep_p1_cb",   model(0, a0 + 1, 0).cb, 50);
    pin("rep_p1_cr",   model(0, a0 + 1, 0).cr, 60);
    pin("int_p1_cb",   model(1, a0 + 1, 0).cb, 60);
    pin("int_p1_cr",   model(1, a0 + 1, 0).cr, 70);
    pin("int_p3_cb",   model(1, a0 + 3, 0).cb, 70);
    pin("odd3_cb",     model(0, b0 + 2, 0).cb, 101);
    pin("odd3_cr",     model(0, b0 + 2, 0).cr, 200);
    pin("int_odd3_cb", model(1, b0 + 1, 0).cb, 101);
    pin("single_cb",   model(0, c0, 0).cb, 33);
    pin("single_cr",   model(0, c0, 0).cr, 128);
    pin("round_1_2",   model(1, d0 + 1, 0).cb, 2);
    pin("round_255",   model(1, d0 + 5, 0).cb, 255);
    pin("lone_int_cb", model(1, e0 + 3, 0).cb, 14);
    pin("lone_int_cr", model(1, e0 + 3, 0).cr, 14);
    pin("line2_cb",    model(0, e0 + 6, 0).cb, 21);
    pin("blank_y",     model(0, a0 - 1, 0).y, 0);

    rst = 1'b1;
    drive(N);
    repeat (3) @(posedge clk);
    #1;
    rz = model(0, -1, 0);
    chk("reset_rep", o_hs0, o_vs0, o_de0, o_y0, o_cb0, o_cr0, rz);
    chk("reset_int", o_hs1, o_vs1, o_de1, o_y1, o_cb1, o_cr1, rz);
    @(negedge clk);
    rst = 1'b0;
    valid_from = 0;
    drive(0);

    for (int n = 0; n < N; n++) begin
      @(posedge clk);
      #1;
      chk("stream_rep", o_hs0, o_vs0, o_de0, o_y0, o_cb0, o_cr0, model(0, n - 1, valid_from));
      chk("stream_int", o_hs1, o_vs1, o_de1, o_y1, o_cb1, o_cr1, model(1, n - 3, valid_from));
      if (n + 1 < N && hrst[n+1] && !rst) begin
        #1 rst = 1'b1;
        valid_from = n + 1;
        #1;
        chk("async_rst_rep", o_hs0, o_vs0, o_de0, o_y0, o_cb0, o_cr0, rz);
        chk("async_rst_int", o_hs1, o_vs1, o_de1, o_y1, o_cb1, o_cr1, rz);
      end
      @(negedge clk);
      if (rst && !(n + 1 < N && hrst[n+1])) begin
        rst = 1'b0;
        valid_from = n + 1;
      end
      drive(n + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
